// File: rtl/secam_fm_chroma_gen.sv
// SECAM FM chroma generator: Db/Dr line alternation, clamped and delayed deviation, DDS accumulator,
// 32-point sine LUT and ramped envelope. Define SECAM_ID_LINES_EN to enable identification lines.
`ifndef SECAM_CHROMA_DB_DDS_INCREMENT
`define SECAM_CHROMA_DB_DDS_INCREMENT 51'd354448766297240
`endif
`ifndef SECAM_CHROMA_DR_DDS_INCREMENT
`define SECAM_CHROMA_DR_DDS_INCREMENT 51'd367484893418381
`endif

module secam_fm_chroma_gen #(
    parameter int unsigned        PHASE_W     = 51,
    parameter int unsigned        LUT_ADDR_W  = 5,
    parameter int unsigned        AMPL_W      = 6,
    parameter int unsigned        DEV_W       = 13,
    parameter int unsigned        DEV_SHIFT   = 35,
    parameter int unsigned        DEV_LIMIT   = 2047,
    parameter int unsigned        DELAY_DEPTH = 32,
    parameter logic [PHASE_W-1:0] DB_INC      = PHASE_W'(`SECAM_CHROMA_DB_DDS_INCREMENT),
    parameter logic [PHASE_W-1:0] DR_INC      = PHASE_W'(`SECAM_CHROMA_DR_DDS_INCREMENT),
    parameter int unsigned        ID_FIRST    = 7,
    parameter int unsigned        ID_LAST     = 15,
    parameter int unsigned        ID_DEV      = 1500
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           newframe,
    input  logic                           line_start,
    input  logic                           active,
    input  logic signed [DEV_W-1:0]        db_in,
    input  logic signed [DEV_W-1:0]        dr_in,
    input  logic [$clog2(DELAY_DEPTH)-1:0] latency,
    input  logic [AMPL_W-1:0]              ampl_target,
    input  logic [AMPL_W-1:0]              ramp_step,
    output logic signed [7:0]              chroma,
    output logic                           line_is_db,
    output logic                           id_line,
    output logic                           env_busy
);
    localparam int unsigned LatW = $clog2(DELAY_DEPTH);
    localparam logic signed [DEV_W-1:0] DevMax   = DEV_W'(DEV_LIMIT);
    localparam logic signed [DEV_W-1:0] DevMin   = -DevMax;
    localparam logic signed [DEV_W-1:0] IdDevPos = DEV_W'(ID_DEV);
    localparam logic signed [DEV_W-1:0] IdDevNeg = -IdDevPos;
    localparam logic signed [AMPL_W+8:0] SatHi   = (AMPL_W+9)'(127);
    localparam logic signed [AMPL_W+8:0] SatLo   = (AMPL_W+9)'(-128);
`ifdef SECAM_ID_LINES_EN
    localparam bit IdEn = 1'b1;
`else
    localparam bit IdEn = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StRampUp, StPlateau, StRampDown} env_state_e;

    logic [9:0]               line_cnt_q;
    logic signed [DEV_W-1:0]  dev_sel, dev_clamp, dev_q;
    logic                     dev_db_q;
    logic [DEV_W:0]           dly_mem [DELAY_DEPTH];
    logic [LatW-1:0]          wr_ptr_q, rd_ptr;
    logic [DEV_W:0]           dly_out;
    logic signed [DEV_W-1:0]  dly_dev;
    logic                     dly_db;
    logic [PHASE_W-1:0]       dev_term, inc_d, inc_q, acc_q;
    logic [LUT_ADDR_W-1:0]    lut_addr;
    logic signed [7:0]        lut_q, chroma_d;
    logic [AMPL_W-1:0]        ampl_q, ampl_d1_q, step, up_next, dn_next;
    logic [AMPL_W:0]          up_sum;
    logic signed [AMPL_W+8:0] prod, scaled;
    env_state_e               state_q;

    // Line sequencing; newframe has priority over line_start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_cnt_q <= '0;
            line_is_db <= 1'b1;
        end else if (newframe) begin
            line_cnt_q <= '0;
            line_is_db <= 1'b1;
        end else if (line_start) begin
            if (line_cnt_q != 10'd1023) line_cnt_q <= line_cnt_q + 10'd1;
            line_is_db <= ~line_is_db;
        end
    end

    assign id_line = IdEn && (line_cnt_q >= 10'(ID_FIRST)) && (line_cnt_q <= 10'(ID_LAST));

    always_comb begin
        dev_sel = line_is_db ? db_in : dr_in;
        if (id_line) dev_sel = line_is_db ? IdDevPos : IdDevNeg;
        dev_clamp = dev_sel;
        if (dev_sel > DevMax)      dev_clamp = DevMax;
        else if (dev_sel < DevMin) dev_clamp = DevMin;
    end

    // The line parity travels with the deviation so the increment formula matches its source line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dev_q    <= '0;
            dev_db_q <= 1'b1;
            wr_ptr_q <= '0;
            for (int i = 0; i < int'(DELAY_DEPTH); i++) dly_mem[i] <= {1'b1, {DEV_W{1'b0}}};
        end else begin
            dev_q             <= dev_clamp;
            dev_db_q          <= line_is_db;
            dly_mem[wr_ptr_q] <= {dev_db_q, dev_q};
            wr_ptr_q          <= wr_ptr_q + 1'b1;
        end
    end

    assign rd_ptr            = wr_ptr_q - latency;
    assign dly_out           = (latency == '0) ? {dev_db_q, dev_q} : dly_mem[rd_ptr];
    assign {dly_db, dly_dev} = dly_out;
    assign dev_term          = {{(PHASE_W-DEV_W){dly_dev[DEV_W-1]}}, dly_dev} << DEV_SHIFT;
    assign inc_d             = dly_db ? DB_INC + dev_term : DR_INC - dev_term;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inc_q <= DB_INC;
            acc_q <= '0;
        end else begin
            inc_q <= inc_d;
            acc_q <= acc_q + inc_q;
        end
    end

    // Half-wave magnitude table indexed by the low four bits; the top bit selects the sign.
    function automatic logic signed [7:0] sine32(input logic [4:0] idx);
        logic signed [7:0] mag;
        unique case (idx[3:0])
            4'd0:  mag = 8'sd0;
            4'd1:  mag = 8'sd25;
            4'd2:  mag = 8'sd49;
            4'd3:  mag = 8'sd71;
            4'd4:  mag = 8'sd90;
            4'd5:  mag = 8'sd106;
            4'd6:  mag = 8'sd117;
            4'd7:  mag = 8'sd125;
            4'd8:  mag = 8'sd127;
            4'd9:  mag = 8'sd125;
            4'd10: mag = 8'sd117;
            4'd11: mag = 8'sd106;
            4'd12: mag = 8'sd90;
            4'd13: mag = 8'sd71;
            4'd14: mag = 8'sd49;
            4'd15: mag = 8'sd25;
        endcase
        return idx[4] ? -mag : mag;
    endfunction

    assign lut_addr = acc_q[PHASE_W-1 -: LUT_ADDR_W];
    assign prod     = lut_q * $signed({1'b0, ampl_d1_q});
    assign scaled   = prod >>> (AMPL_W - 1);

    always_comb begin
        chroma_d = scaled[7:0];
        if (scaled > SatHi)      chroma_d = 8'sd127;
        else if (scaled < SatLo) chroma_d = -8'sd128;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lut_q     <= '0;
            ampl_d1_q <= '0;
            chroma    <= '0;
        end else begin
            lut_q     <= sine32(lut_addr[LUT_ADDR_W-1 -: 5]);
            ampl_d1_q <= ampl_q;
            chroma    <= chroma_d;
        end
    end

    // A zero ramp_step means jump straight to the limit.
    always_comb begin
        step    = (ramp_step == '0) ? '1 : ramp_step;
        up_sum  = {1'b0, ampl_q} + {1'b0, step};
        up_next = (up_sum > {1'b0, ampl_target}) ? ampl_target : up_sum[AMPL_W-1:0];
        dn_next = (ampl_q > step) ? ampl_q - step : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ampl_q  <= '0;
        end else if (id_line) begin
            state_q <= StPlateau;
            ampl_q  <= ampl_target;
        end else begin
            unique case (state_q)
                StIdle: if (active) state_q <= StRampUp;
                StRampUp: begin
                    if (!active) begin
                        state_q <= StRampDown;
                    end else begin
                        ampl_q <= up_next;
                        if (up_next == ampl_target) state_q <= StPlateau;
                    end
                end
                StPlateau: begin
                    ampl_q <= ampl_target;
                    if (!active) state_q <= StRampDown;
                end
                StRampDown: begin
                    if (active) begin
                        state_q <= StRampUp;
                    end else begin
                        ampl_q <= dn_next;
                        if (dn_next == '0) state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign env_busy = (state_q != StIdle);

endmodule

// File: tb/tb_secam_fm_chroma_gen.sv
// Bench for secam_fm_chroma_gen: directed steps and random stimulus compared every cycle against
// a cycle-level behavioural model of the line, deviation, DDS and envelope rules.
module tb_secam_fm_chroma_gen;
    localparam int     DevShift = 35;
    localparam int     DevLimit = 2047;
    localparam int     IdFirst  = 7;
    localparam int     IdLast   = 15;
    localparam int     IdDev    = 1500;
    localparam longint DbInc    = 64'd354448766297240;
    localparam longint DrInc    = 64'd367484893418381;
    localparam longint Mask     = (64'd1 << 51) - 64'd1;
    localparam int     MaxC     = 4096;
    localparam int     MIdle = 0, MUp = 1, MPlat = 2, MDown = 3;
`ifdef SECAM_ID_LINES_EN
    localparam bit IdEn = 1'b1;
`else
    localparam bit IdEn = 1'b0;
`endif

    logic              clk = 1'b0, rst_n = 1'b0;
    logic              newframe = 1'b0, line_start = 1'b0, active = 1'b0;
    logic signed [12:0] db_in = '0, dr_in = '0;
    logic [4:0]        latency = '0;
    logic [5:0]        ampl_target = '0, ramp_step = '0;
    logic signed [7:0] chroma;
    logic              line_is_db, id_line, env_busy;

    int tests = 0, fails = 0;

    int     n, m_cnt, m_mode, m_amp;
    bit     m_db;
    int     h_dev [MaxC];
    bit     h_db  [MaxC];
    int     h_lat [MaxC];
    longint h_acc [MaxC];
    longint h_inc [MaxC];
    int     h_amp [MaxC];

    secam_fm_chroma_gen #(.DB_INC(51'(DbInc)), .DR_INC(51'(DrInc))) dut (
        .clk(clk), .rst_n(rst_n), .newframe(newframe), .line_start(line_start), .active(active),
        .db_in(db_in), .dr_in(dr_in), .latency(latency), .ampl_target(ampl_target),
        .ramp_step(ramp_step), .chroma(chroma), .line_is_db(line_is_db), .id_line(id_line),
        .env_busy(env_busy)
    );

    always #5 clk = ~clk;

    function automatic int sine(input int idx);
        real v;
        v = 127.0 * $sin(2.0 * 3.14159265358979 * idx / 32.0);
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
    endfunction

    function automatic longint inc_of(input int dev, input bit db);
        longint t;
        t = longint'(dev) <<< DevShift;
        return (db ? DbInc + t : DrInc - t) & Mask;
    endfunction

    function automatic bit id_of(input int cnt);
        return IdEn && cnt >= IdFirst && cnt <= IdLast;
    endfunction

    function automatic int     dev_at(input int k); return (k < 0) ? 0 : h_dev[k]; endfunction
    function automatic bit     db_at (input int k); return (k < 0) ? 1'b1 : h_db[k]; endfunction
    function automatic longint acc_at(input int k); return (k < 0) ? 64'd0 : h_acc[k]; endfunction
    function automatic int     amp_at(input int k); return (k < 0) ? 0 : h_amp[k]; endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cycle %0d: got %0d expected %0d", tag, n, $signed(obs), $signed(exp));
        end
    endtask

    task automatic model_reset();
        n = 0; m_cnt = 0; m_db = 1'b1; m_mode = MIdle; m_amp = 0;
        h_acc[0] = 0; h_amp[0] = 0; h_inc[0] = DbInc;
    endtask

    task automatic check_now();
        int     idx, v;
        longint a;
        a   = acc_at(n - 2);
        idx = int'((a >> 46) & 64'd31);
        v   = (sine(idx) * amp_at(n - 2)) >>> 5;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        chk("line_is_db", line_is_db, m_db);
        chk("id_line", id_line, id_of(m_cnt));
        chk("env_busy", env_busy, m_mode != MIdle);
        chk("ampl", dut.ampl_q, h_amp[n]);
        chk("inc", dut.inc_q, h_inc[n]);
        chk("acc", dut.acc_q, h_acc[n]);
        chk("chroma", chroma, longint'(v));
    endtask

    // Record this cycle's inputs, clock once, then advance the model and compare.
    task automatic tick();
        int sel, stp, tgt, k;
        sel = m_db ? int'(db_in) : int'(dr_in);
        if (id_of(m_cnt)) sel = m_db ? IdDev : -IdDev;
        if (sel > DevLimit) sel = DevLimit;
        else if (sel < -DevLimit) sel = -DevLimit;
        h_dev[n] = sel; h_db[n] = m_db; h_lat[n] = int'(latency);
        @(posedge clk); #1;
        tgt = int'(ampl_target);
        stp = (ramp_step == 0) ? 63 : int'(ramp_step);
        if (id_of(m_cnt)) begin
            m_mode = MPlat; m_amp = tgt;
        end else begin
            case (m_mode)
                MIdle: if (active) m_mode = MUp;
                MUp: if (!active) m_mode = MDown;
                     else begin
                         m_amp = (m_amp + stp > tgt) ? tgt : m_amp + stp;
                         if (m_amp == tgt) m_mode = MPlat;
                     end
                MPlat: begin m_amp = tgt; if (!active) m_mode = MDown; end
                default: if (active) m_mode = MUp;
                     else begin
                         m_amp = (m_amp > stp) ? m_amp - stp : 0;
                         if (m_amp == 0) m_mode = MIdle;
                     end
            endcase
        end
        if (newframe) begin
            m_cnt = 0; m_db = 1'b1;
        end else if (line_start) begin
            if (m_cnt < 1023) m_cnt++;
            m_db = ~m_db;
        end
        k = n - 1 - h_lat[n];
        h_inc[n+1] = inc_of(dev_at(k), db_at(k));
        h_acc[n+1] = (h_acc[n] + h_inc[n]) & Mask;
        h_amp[n+1] = m_amp;
        n++;
        check_now();
    endtask

    task automatic rand_cycles(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            newframe   = ($urandom_range(0, 199) == 0);
            line_start = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 19) == 0) active = ~active;
            if ($urandom_range(0, 9) == 0) db_in = 13'($urandom_range(0, 8191));
            if ($urandom_range(0, 9) == 0) dr_in = 13'($urandom_range(0, 8191));
            if ($urandom_range(0, 49) == 0) latency = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 29) == 0) begin
                ampl_target = 6'($urandom_range(0, 63));
                ramp_step   = 6'($urandom_range(0, 7));
            end
            tick();
        end
        newframe = 1'b0; line_start = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        check_now();

        // Idle with one line toggle.
        repeat (10) tick();
        line_start = 1'b1; tick(); line_start = 1'b0;
        repeat (89) tick();

        // Envelope ramp up and down.
        ampl_target = 6'd32; ramp_step = 6'd4; active = 1'b1;
        repeat (9) tick();
        chk("ramp_up_32", dut.ampl_q, 32);
        active = 1'b0;
        repeat (9) tick();
        chk("ramp_down_0", dut.ampl_q, 0);
        chk("idle_after_ramp", env_busy, 1'b0);

        // Deviation latency of 5 on a Db line.
        newframe = 1'b1; tick(); newframe = 1'b0;
        latency = 5'd5; db_in = '0;
        repeat (40) tick();
        db_in = 13'sd100;
        repeat (6) tick();
        chk("lat_hold", dut.inc_q, inc_of(0, 1'b1));
        tick();
        chk("lat_step", dut.inc_q, inc_of(100, 1'b1));

        // Clamping on Db and Dr lines.
        latency = '0; db_in = 13'sd4000;
        repeat (3) tick();
        chk("clamp_db", dut.inc_q, (DbInc + (64'd2047 << 35)) & Mask);
        line_start = 1'b1; tick(); line_start = 1'b0;
        dr_in = -13'sd4000;
        repeat (3) tick();
        chk("clamp_dr", dut.inc_q, (DrInc + (64'd2047 << 35)) & Mask);

        // newframe beats line_start, then three lines.
        newframe = 1'b1; line_start = 1'b1; tick();
        newframe = 1'b0; line_start = 1'b0;
        chk("nf_wins_db", line_is_db, 1'b1);
        chk("nf_wins_cnt", dut.line_cnt_q, 0);
        repeat (3) begin line_start = 1'b1; tick(); line_start = 1'b0; tick(); end
        chk("three_lines_db", line_is_db, 1'b0);
        chk("three_lines_cnt", dut.line_cnt_q, 3);

        // Reach line 7 with active low.
        ampl_target = 6'd20; ramp_step = 6'd3; db_in = 13'sd300; dr_in = -13'sd300;
        repeat (4) begin line_start = 1'b1; tick(); line_start = 1'b0; tick(); end
        chk("id_line7", id_line, IdEn);
        chk("id_ampl", dut.ampl_q, IdEn ? 20 : 0);
        chk("id_dev", dut.dev_q, IdEn ? -64'sd1500 : -64'sd300);

        rand_cycles(1500);

        // Asynchronous reset mid-operation.
        #3 rst_n = 1'b0;
        #1;
        chk("async_chroma", chroma, 0);
        chk("async_busy", env_busy, 1'b0);
        chk("async_db", line_is_db, 1'b1);
        chk("async_acc", dut.acc_q, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        model_reset();
        check_now();
        rand_cycles(300);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
